// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: host command/response port plus APB initiator bus, bundled for the bridge.
interface apb_master_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;
   logic              busy;
   logic              PSELx;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
             PSELx, PENABLE, PWRITE, PADDR, PWDATA
   );
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
             PSELx, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-command APB initiator with registered outputs and wait-state timeout.
module apb_master_bridge #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                 PCLK,
   input logic                 PRESETn,
   apb_master_bridge_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);
   state_t            state, state_d;
   logic [15:0]       wait_cnt, wait_cnt_d;
   logic              psel, psel_d, penable, penable_d, pwrite, pwrite_d;
   logic              rvalid, rvalid_d, rerr, rerr_d, rto, rto_d;
   logic [ADDR_W-1:0] paddr, paddr_d;
   logic [DATA_W-1:0] pwdata, pwdata_d, rdata, rdata_d;
   logic              timed_out;
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         state    <= IDLE;
         wait_cnt <= '0;
         psel     <= 1'b0;
         penable  <= 1'b0;
         pwrite   <= 1'b0;
         paddr    <= '0;
         pwdata   <= '0;
         rvalid   <= 1'b0;
         rdata    <= '0;
         rerr     <= 1'b0;
         rto      <= 1'b0;
      end else begin
         state    <= state_d;
         wait_cnt <= wait_cnt_d;
         psel     <= psel_d;
         penable  <= penable_d;
         pwrite   <= pwrite_d;
         paddr    <= paddr_d;
         pwdata   <= pwdata_d;
         rvalid   <= rvalid_d;
         rdata    <= rdata_d;
         rerr     <= rerr_d;
         rto      <= rto_d;
      end
   // PSLVERR and PRDATA only matter on the PREADY cycle; a timeout wins otherwise
   always_comb begin
      state_d    = state;
      wait_cnt_d = wait_cnt;
      psel_d     = psel;
      penable_d  = penable;
      pwrite_d   = pwrite;
      paddr_d    = paddr;
      pwdata_d   = pwdata;
      rvalid_d   = rvalid;
      rdata_d    = rdata;
      rerr_d     = rerr;
      rto_d      = rto;
      timed_out  = (TIMEOUT_CYCLES != 0) && (wait_cnt == LAST_WAIT);
      case (state)
         IDLE:
            if (bus.cmd_valid) begin
               state_d  = SETUP;
               psel_d   = 1'b1;
               pwrite_d = bus.cmd_write;
               paddr_d  = bus.cmd_addr;
               pwdata_d = bus.cmd_wdata;
            end
         SETUP: begin
            state_d    = ACCESS;
            penable_d  = 1'b1;
            wait_cnt_d = '0;
         end
         ACCESS:
            if (bus.PREADY || timed_out) begin
               state_d   = RESP;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               rvalid_d  = 1'b1;
               rdata_d   = (bus.PREADY && !pwrite) ? bus.PRDATA : '0;
               rerr_d    = bus.PREADY ? bus.PSLVERR : 1'b1;
               rto_d     = !bus.PREADY;
            end else if (wait_cnt != 16'hFFFF) begin
               wait_cnt_d = wait_cnt + 16'd1;
            end
         RESP:
            if (bus.rsp_ready) begin
               state_d  = IDLE;
               rvalid_d = 1'b0;
               rerr_d   = 1'b0;
               rto_d    = 1'b0;
            end
         default: state_d = IDLE;
      endcase
   end
   assign bus.cmd_ready   = state == IDLE;
   assign bus.busy        = state != IDLE;
   assign bus.PSELx       = psel;
   assign bus.PENABLE     = penable;
   assign bus.PWRITE      = pwrite;
   assign bus.PADDR       = paddr;
   assign bus.PWDATA      = pwdata;
   assign bus.rsp_valid   = rvalid;
   assign bus.rsp_rdata   = rdata;
   assign bus.rsp_err     = rerr;
   assign bus.rsp_timeout = rto;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: table-driven and randomized checks of the APB bridge against a timeline model.
module tb_apb_master_bridge;
   localparam int T = 16;
   logic PCLK    = 1'b0;
   logic PRESETn = 1'b0;
   always #5 PCLK = ~PCLK;
   apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
   apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus));
   apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(1)) dut1 (
      .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus1));
   typedef struct {
      logic        wr;
      logic [31:0] addr, wdata, prdata;
      int          waits;
      logic        perr, early, hold;
      int          bp;
      logic [31:0] e_rdata;
      logic        e_err, e_to;
      int          e_lat;
   } vec_t;
   vec_t tbl[10];
   int n_vec = 0;
   int n_bad = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask
   // expected response from the transfer rules: slave ready after `waits` stalls vs the timeout budget
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      logic to = v.waits >= T;
      r.e_to    = to;
      r.e_err   = to || v.perr;
      r.e_rdata = (to || v.wr) ? 32'h0 : v.prdata;
      r.e_lat   = to ? T + 1 : v.waits + 2;
      return r;
   endfunction
   // called at a negedge with the bridge idle; returns at the negedge after the response handshake
   task automatic run(input vec_t v);
      chk("cmd_ready_idle", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = v.wr;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      @(posedge PCLK);
      for (int e = 0; e <= v.e_lat + v.bp + 1; e++) begin
         @(negedge PCLK);
         if (e == 0) begin
            bus.cmd_valid = v.hold;
            bus.cmd_addr  = ~v.addr;
            bus.cmd_wdata = ~v.wdata;
            bus.cmd_write = ~v.wr;
         end
         if (e < v.e_lat) begin
            chk("psel", bus.PSELx, 1);
            chk("penable", bus.PENABLE, 64'(e >= 1));
            chk("rsp_valid_early", bus.rsp_valid, 0);
            chk("cmd_ready_busy", bus.cmd_ready, 0);
            chk("busy", bus.busy, 1);
            chk("paddr", bus.PADDR, v.addr);
            chk("pwdata", bus.PWDATA, v.wdata);
            chk("pwrite", bus.PWRITE, v.wr);
         end else if (e <= v.e_lat + v.bp) begin
            chk("psel_resp", bus.PSELx, 0);
            chk("penable_resp", bus.PENABLE, 0);
            chk("rsp_valid", bus.rsp_valid, 1);
            chk("rsp_rdata", bus.rsp_rdata, v.e_rdata);
            chk("rsp_err", bus.rsp_err, v.e_err);
            chk("rsp_timeout", bus.rsp_timeout, v.e_to);
            chk("cmd_ready_resp", bus.cmd_ready, 0);
         end else begin
            chk("rsp_valid_clr", bus.rsp_valid, 0);
            chk("rsp_err_clr", bus.rsp_err, 0);
            chk("rsp_timeout_clr", bus.rsp_timeout, 0);
            chk("busy_clr", bus.busy, 0);
         end
         bus.PREADY    = (e >= 1) && (e - 1 == v.waits);
         bus.PSLVERR   = bus.PREADY ? v.perr : v.early;
         bus.PRDATA    = bus.PREADY ? v.prdata : $urandom;
         bus.rsp_ready = e >= v.e_lat + v.bp;
      end
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;
      bus.rsp_ready = 1'b0;
   endtask
   initial begin
      vec_t v;
      bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
      bus.rsp_ready = 0; bus.PRDATA = 0; bus.PREADY = 0; bus.PSLVERR = 0;
      bus1.cmd_valid = 0; bus1.cmd_write = 0; bus1.cmd_addr = 0; bus1.cmd_wdata = 0;
      bus1.rsp_ready = 0; bus1.PRDATA = 0; bus1.PREADY = 0; bus1.PSLVERR = 0;
      //          wr addr    wdata        prdata        wt pe er hd bp  rdata         err to lat
      tbl[0] = '{1, 32'h08, 32'h1ABC,    32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 0, 2};
      tbl[1] = '{0, 32'h04, 32'h0,       32'hA5A50001, 3, 0, 0, 0, 0, 32'hA5A50001, 0, 0, 5};
      tbl[2] = '{0, 32'h0C, 32'h0,       32'hDEAD0000, 2, 1, 1, 0, 0, 32'hDEAD0000, 1, 0, 4};
      tbl[3] = '{0, 32'h10, 32'h0,       32'h12345678, 4, 0, 1, 0, 0, 32'h12345678, 0, 0, 6};
      tbl[4] = '{0, 32'h14, 32'h0,       32'hFFFFFFFF, 40, 0, 0, 0, 0, 32'h0,       1, 1, 17};
      tbl[5] = '{1, 32'h18, 32'hCAFE,    32'hBEEF,     1, 0, 0, 1, 5, 32'h0,        0, 0, 3};
      tbl[6] = '{0, 32'h1C, 32'h0,       32'h55AA,     0, 0, 0, 0, 0, 32'h55AA,     0, 0, 2};
      tbl[7] = '{0, 32'h20, 32'h0,       32'h7777,     15, 0, 1, 0, 0, 32'h7777,    0, 0, 17};
      tbl[8] = '{1, 32'h24, 32'h1,       32'h0,        16, 1, 0, 0, 1, 32'h0,       1, 1, 17};
      tbl[9] = '{1, 32'h28, 32'h3,       32'h0,        0, 1, 0, 0, 0, 32'h0,        1, 0, 2};
      #1;
      chk("rst_psel", bus.PSELx, 0);
      chk("rst_penable", bus.PENABLE, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_paddr", bus.PADDR, 0);
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      for (int i = 0; i < 10; i++) run(tbl[i]);
      for (int i = 0; i < 40; i++) begin
         v.wr     = 1'($urandom_range(0, 1));
         v.addr   = $urandom & 32'hFFFC;
         v.wdata  = $urandom;
         v.prdata = $urandom;
         v.waits  = $urandom_range(0, 20);
         v.perr   = 1'($urandom_range(0, 1));
         v.early  = 1'($urandom_range(0, 1));
         v.hold   = 1'($urandom_range(0, 1));
         v.bp     = $urandom_range(0, 3);
         run(model(v));
      end
      // asynchronous reset while the slave is stalling
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h40;
      @(posedge PCLK);
      @(negedge PCLK);
      bus.cmd_valid = 1'b0;
      repeat (3) @(negedge PCLK);
      chk("pre_rst_penable", bus.PENABLE, 1);
      #2 PRESETn = 1'b0;
      #1;
      chk("mid_rst_psel", bus.PSELx, 0);
      chk("mid_rst_penable", bus.PENABLE, 0);
      chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
      chk("mid_rst_busy", bus.busy, 0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      v = '{0, 32'h44, 32'h0, 32'h0BADF00D, 2, 0, 0, 0, 1, 32'h0, 0, 0, 0};
      run(model(v));
      // one-cycle timeout budget: stall aborts on the first ACCESS cycle
      bus1.cmd_valid = 1'b1; bus1.cmd_addr = 32'h50;
      @(posedge PCLK);
      @(negedge PCLK);
      bus1.cmd_valid = 1'b0;
      chk("t1_psel", bus1.PSELx, 1);
      @(negedge PCLK);
      chk("t1_penable", bus1.PENABLE, 1);
      chk("t1_rsp_valid_early", bus1.rsp_valid, 0);
      @(negedge PCLK);
      chk("t1_rsp_valid", bus1.rsp_valid, 1);
      chk("t1_timeout", bus1.rsp_timeout, 1);
      chk("t1_err", bus1.rsp_err, 1);
      chk("t1_psel_drop", bus1.PSELx, 0);
      bus1.rsp_ready = 1'b1;
      @(negedge PCLK);
      bus1.rsp_ready = 1'b0;
      chk("t1_rsp_clr", bus1.rsp_valid, 0);
      bus1.cmd_valid = 1'b1; bus1.cmd_addr = 32'h54;
      @(posedge PCLK);
      @(negedge PCLK);
      bus1.cmd_valid = 1'b0;
      bus1.PREADY = 1'b1; bus1.PRDATA = 32'h99;
      repeat (2) @(negedge PCLK);
      bus1.PREADY = 1'b0;
      chk("t1_ok_valid", bus1.rsp_valid, 1);
      chk("t1_ok_timeout", bus1.rsp_timeout, 0);
      chk("t1_ok_rdata", bus1.rsp_rdata, 32'h99);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
